// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM state encoding,
// RV32I width codes, and the alignment / byte-lane rules used by the top.
package lsu_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } lsu_state_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Undefined width codes are folded into the misaligned case so they
   // never reach the bus.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B, F3_BU: return 1'b0;
         F3_H, F3_HU: return a[0];
         F3_W:        return (a != 2'b00);
         default:     return 1'b1;
      endcase
   endfunction

   // Byte enables for the addressed lane(s); f3[2] only selects extension.
   function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   // Store data replicated across all lanes so memory can pick any lane.
   function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'b00:   return {4{wd[7:0]}};
         2'b01:   return {2{wd[15:0]}};
         default: return wd;
      endcase
   endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational lane select and sign/zero extension of a read word.
module load_extend
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] word,
   output logic [31:0] result
);

   logic [7:0]  lane_byte;
   logic [15:0] lane_half;

   // Pick the addressed byte/half, then extend according to the width code.
   always_comb begin
      // NOTE: every output of a combinational block is assigned on every path
      // (defaults first) so no latch can be inferred.
      lane_byte = word[7:0];
      lane_half = addr_lo[1] ? word[31:16] : word[15:0];
      result    = word;
      case (addr_lo)
         2'd0: lane_byte = word[7:0];
         2'd1: lane_byte = word[15:8];
         2'd2: lane_byte = word[23:16];
         2'd3: lane_byte = word[31:24];
         default: lane_byte = word[7:0];
      endcase
      case (funct3)
         F3_B:    result = {{24{lane_byte[7]}}, lane_byte};
         F3_BU:   result = {24'b0, lane_byte};
         F3_H:    result = {{16{lane_half[15]}}, lane_half};
         F3_HU:   result = {16'b0, lane_half};
         default: result = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request from execute, runs a single bus
// access with a timeout, and reports completion with a done/err pulse.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] ld_data,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   // Counter holds 0..TIMEOUT_CYC-1; the last value is the final wait cycle.
   localparam int unsigned       CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   lsu_state_e        state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [31:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;
   logic [31:0]       ld_data_q, ld_data_d;
   logic [31:0]       ld_ext;

   load_extend u_load_extend (
      .funct3  (funct3_q),
      .addr_lo (addr_q[1:0]),
      .word    (bus_rdata),
      .result  (ld_ext)
   );

   // State and request registers, all cleared by a synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge value of every other flop.
      if (!rst_n) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         funct3_q  <= 3'b000;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         ld_data_q <= 32'h0;
      end else begin
         state_q   <= state_d;
         we_q      <= we_d;
         funct3_q  <= funct3_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         ld_data_q <= ld_data_d;
      end
   end

   // Next-state logic: accept in IDLE, wait for ready or timeout in ACCESS.
   always_comb begin
      state_d   = state_q;
      we_d      = we_q;
      funct3_d  = funct3_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      err_d     = err_q;
      ld_data_d = ld_data_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               we_d     = req_we;
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               cnt_d    = '0;
               if (is_misaligned(req_funct3, req_addr[1:0])) begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  err_d   = 1'b0;
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            // Ready wins over timeout in the final wait cycle.
            if (bus_ready) begin
               state_d = DONE;
               cnt_d   = '0;
               if (!we_q) begin
                  ld_data_d = ld_ext;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               err_d   = 1'b1;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Outputs decoded from the state; bus controls are gated to ACCESS.
   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      err       = (state_q == DONE) && err_q;
      bus_req   = (state_q == ACCESS);
      bus_we    = bus_req && we_q;
      bus_be    = bus_req ? byte_enables(funct3_q, addr_q[1:0]) : 4'b0000;
      bus_addr  = {addr_q[31:2], 2'b00};
      bus_wdata = lane_wdata(funct3_q, wdata_q);
      ld_data   = ld_data_q;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, a reset
// abort sequence, and randomized transactions against a behavioural model.
module tb_load_store_unit;

   localparam int TB_TIMEOUT = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [31:0] ld_data;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_ready;
   logic [31:0] bus_rdata;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          delay;      // ACCESS cycles before bus_ready rises
      int          cycles;     // expected number of bus_req cycles
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic        exp_err;
      logic [31:0] exp_ld;     // ld_data expected after completion
   } txn_t;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model_ld;
   txn_t        vec [13];
   logic [2:0]  load_f3  [10] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101,
                                  3'b000, 3'b001, 3'b010, 3'b011, 3'b111};
   logic [2:0]  store_f3 [10] = '{3'b000, 3'b001, 3'b010, 3'b000, 3'b001,
                                  3'b010, 3'b000, 3'b001, 3'b010, 3'b110};

   load_store_unit #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .ld_data    (ld_data),
      .bus_req    (bus_req),
      .bus_we     (bus_we),
      .bus_addr   (bus_addr),
      .bus_be     (bus_be),
      .bus_wdata  (bus_wdata),
      .bus_ready  (bus_ready),
      .bus_rdata  (bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      check(name, {31'b0, act}, {31'b0, exp});
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   function automatic logic ref_bad(input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
      if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
      if (f3 == 3'b010) return (a % 4) != 0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
      int sh;
      sh = int'(a % 4);
      if (f3 == 3'b010) return 4'hF;
      if (f3 == 3'b001 || f3 == 3'b101) return 4'(3 << sh);
      return 4'(1 << sh);
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (f3 == 3'b000) return {24'b0, wd[7:0]} * 32'h0101_0101;
      if (f3 == 3'b001) return {16'b0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] shifted;
      int          v;
      shifted = rd >> (8 * (a % 4));
      if (f3 == 3'b000 || f3 == 3'b100) begin
         v = int'(shifted & 32'hFF);
         if (f3 == 3'b000 && v >= 128) v = v - 256;
      end else if (f3 == 3'b001 || f3 == 3'b101) begin
         v = int'(shifted & 32'hFFFF);
         if (f3 == 3'b001 && v >= 32768) v = v - 65536;
      end else begin
         return rd;
      end
      return 32'(v);
   endfunction

   // Run one request end to end and compare every cycle against t.
   task automatic run_txn(input txn_t t);
      // NOTE: bench inputs are driven with blocking assignments after the
      // edge, so the DUT sees them settled at the next rising edge.
      req_valid  = 1'b1;
      req_we     = t.we;
      req_funct3 = t.f3;
      req_addr   = t.addr;
      req_wdata  = t.wdata;
      step();
      // Garbage request while busy must be ignored.
      req_we     = ~t.we;
      req_funct3 = 3'b010;
      req_addr   = $urandom;
      req_wdata  = $urandom;
      for (int k = 0; k < t.cycles; k++) begin
         check_bit("access_busy", busy, 1'b1);
         check_bit("access_bus_req", bus_req, 1'b1);
         check_bit("access_done", done, 1'b0);
         check_bit("bus_we", bus_we, t.we);
         check("bus_addr", bus_addr, {t.addr[31:2], 2'b00});
         check("bus_be", {28'b0, bus_be}, {28'b0, t.exp_be});
         if (t.we) check("bus_wdata", bus_wdata, t.exp_wdata);
         if (k == t.delay) begin
            bus_ready = 1'b1;
            bus_rdata = t.rdata;
         end else begin
            bus_ready = 1'b0;
            bus_rdata = $urandom;
         end
         step();
      end
      bus_ready = 1'b0;
      req_valid = 1'b0;
      check_bit("done_pulse", done, 1'b1);
      check_bit("done_err", err, t.exp_err);
      check_bit("done_busy", busy, 1'b1);
      check_bit("done_bus_req", bus_req, 1'b0);
      check("done_ld_data", ld_data, t.exp_ld);
      step();
      check_bit("idle_busy", busy, 1'b0);
      check_bit("idle_done", done, 1'b0);
      check_bit("idle_err", err, 1'b0);
      check("idle_ld_data", ld_data, t.exp_ld);
   endtask

   initial begin
      // Directed table: {we, f3, addr, wdata, rdata, delay, cycles, be, wdata_exp, err, ld}
      vec[0]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF_1234, 0, 1, 4'b1000, 32'h0,        1'b0, 32'hFFFF_FF80};
      vec[1]  = '{1'b0, 3'b101, 32'h102, 32'h0,        32'h8001_0000, 0, 1, 4'b1100, 32'h0,        1'b0, 32'h0000_8001};
      vec[2]  = '{1'b1, 3'b000, 32'h201, 32'hAABB_CC5A, 32'h0,        0, 1, 4'b0010, 32'h5A5A_5A5A, 1'b0, 32'h0000_8001};
      vec[3]  = '{1'b0, 3'b010, 32'h006, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1'b1, 32'h0000_8001};
      vec[4]  = '{1'b0, 3'b001, 32'h002, 32'h0,        32'h9ABC_0000, 2, 3, 4'b1100, 32'h0,        1'b0, 32'hFFFF_9ABC};
      vec[5]  = '{1'b1, 3'b001, 32'h006, 32'h1234_BEEF, 32'h0,        1, 2, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'hFFFF_9ABC};
      vec[6]  = '{1'b0, 3'b100, 32'h001, 32'h0,        32'h0000_F700, 0, 1, 4'b0010, 32'h0,        1'b0, 32'h0000_00F7};
      vec[7]  = '{1'b1, 3'b010, 32'h010, 32'hDEAD_BEEF, 32'h0,        0, 1, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0000_00F7};
      vec[8]  = '{1'b0, 3'b010, 32'h020, 32'h0,        32'h1357_2468, 3, 4, 4'b1111, 32'h0,        1'b0, 32'h1357_2468};
      vec[9]  = '{1'b0, 3'b000, 32'h040, 32'h0,        32'hFFFF_FFFF, 9, 4, 4'b0001, 32'h0,        1'b1, 32'h1357_2468};
      vec[10] = '{1'b0, 3'b011, 32'h000, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1'b1, 32'h1357_2468};
      vec[11] = '{1'b0, 3'b101, 32'h003, 32'h0,        32'h0,         0, 0, 4'b0000, 32'h0,        1'b1, 32'h1357_2468};
      vec[12] = '{1'b1, 3'b001, 32'h001, 32'h0000_0055, 32'h0,        0, 0, 4'b0000, 32'h0,        1'b1, 32'h1357_2468};

      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      bus_ready  = 1'b0;
      bus_rdata  = 32'h0;
      step();
      step();
      check_bit("rst_busy", busy, 1'b0);
      check_bit("rst_done", done, 1'b0);
      check_bit("rst_err", err, 1'b0);
      check_bit("rst_bus_req", bus_req, 1'b0);
      check_bit("rst_bus_we", bus_we, 1'b0);
      check("rst_bus_be", {28'b0, bus_be}, 32'h0);
      check("rst_ld_data", ld_data, 32'h0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 13; i++) begin
         run_txn(vec[i]);
      end

      // Reset in the second ACCESS cycle aborts the load with no done pulse.
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h100;
      step();
      req_valid = 1'b0;
      step();
      check_bit("abort_pre_bus_req", bus_req, 1'b1);
      rst_n = 1'b0;
      step();
      check_bit("abort_bus_req", bus_req, 1'b0);
      check_bit("abort_busy", busy, 1'b0);
      check_bit("abort_done", done, 1'b0);
      check_bit("abort_err", err, 1'b0);
      check_bit("abort_bus_we", bus_we, 1'b0);
      check("abort_bus_be", {28'b0, bus_be}, 32'h0);
      check("abort_ld_data", ld_data, 32'h0);
      rst_n = 1'b1;
      step();
      check_bit("abort_no_done", done, 1'b0);
      model_ld = 32'h0;
      run_txn('{1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80});
      model_ld = 32'hFFFF_FF80;

      // Randomized transactions scored against the reference model.
      for (int n = 0; n < 150; n++) begin
         txn_t t;
         logic bad;
         logic timed_out;
         t.we     = 1'($urandom_range(0, 1));
         t.f3     = t.we ? store_f3[$urandom_range(0, 9)] : load_f3[$urandom_range(0, 9)];
         t.addr   = $urandom;
         t.wdata  = $urandom;
         t.rdata  = $urandom;
         t.delay  = int'($urandom_range(0, 5));
         bad       = ref_bad(t.f3, t.addr);
         timed_out = !bad && (t.delay >= TB_TIMEOUT);
         t.cycles    = bad ? 0 : ((t.delay < TB_TIMEOUT) ? t.delay + 1 : TB_TIMEOUT);
         t.exp_be    = ref_be(t.f3, t.addr);
         t.exp_wdata = ref_wdata(t.f3, t.wdata);
         t.exp_err   = bad || timed_out;
         if (!t.exp_err && !t.we) model_ld = ref_load(t.f3, t.addr, t.rdata);
         t.exp_ld    = model_ld;
         run_txn(t);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
